// File: rtl/ones_count_pattern_gen_if.sv
// Request/result bundle between a ones-count code source and the pattern generator.
interface ones_count_pattern_gen_if;
    logic [2:0] code;
    logic       load;
    logic [3:0] pattern;
    logic       busy;
    logic       done;
    logic       code_err;

    modport master (output code, load, input pattern, busy, done, code_err);
    modport slave  (input code, load, output pattern, busy, done, code_err);
endinterface

// File: rtl/ones_count_pattern_gen.sv
// Generates 4-bit patterns with `code` bits set, rotated once per TICK_DIV cycles; load->pattern 1 cycle, load->done 1+4*TICK_DIV.
// No backpressure: loads in RUN are ignored. PATTERN_GEN_CONTINUOUS_EN makes RUN repeat revolutions and accept restarts.
module ones_count_pattern_gen #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    ones_count_pattern_gen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       step_q, step_d;
    logic [3:0]       pattern_q, pattern_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tick_step;

    function automatic logic [3:0] therm(input logic [2:0] c);
        case (c)
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            default: therm = 4'b0111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            step_q    <= '0;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            step_q    <= step_d;
            pattern_q <= pattern_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        step_d    = step_q;
        pattern_d = pattern_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tick_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    if (bus.code > 3'd4) begin
                        err_d = 1'b1;
                    end else if (bus.code == 3'd0 || bus.code == 3'd4) begin
                        // code[2] alone distinguishes 0 (all clear) from 4 (all set)
                        pattern_d = {4{bus.code[2]}};
                        done_d    = 1'b1;
                    end else begin
                        pattern_d = therm(bus.code);
                        presc_d   = '0;
                        step_d    = '0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                tick_step = 1'b1;
`ifdef PATTERN_GEN_CONTINUOUS_EN
                if (bus.load) begin
                    if (bus.code > 3'd4) begin
                        err_d = 1'b1;
                    end else if (bus.code == 3'd0 || bus.code == 3'd4) begin
                        pattern_d = {4{bus.code[2]}};
                        done_d    = 1'b1;
                        state_d   = IDLE;
                        tick_step = 1'b0;
                    end else begin
                        pattern_d = therm(bus.code);
                        presc_d   = '0;
                        step_d    = '0;
                        tick_step = 1'b0;
                    end
                end
`endif
                if (tick_step) begin
                    if (presc_q == TICK_LAST) begin
                        presc_d   = '0;
                        pattern_d = {pattern_q[2:0], pattern_q[3]};
                        if (step_q == 2'd3) begin
                            // a rejected load in the same cycle wins; done and code_err stay exclusive
                            done_d = ~err_d;
                            step_d = '0;
`ifndef PATTERN_GEN_CONTINUOUS_EN
                            state_d = IDLE;
`endif
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    assign bus.pattern  = pattern_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.code_err = err_q;
endmodule

// File: tb/tb_ones_count_pattern_gen.sv
// Bench for ones_count_pattern_gen: elapsed-time model, per-cycle compare, directed loads with literal checks.
module tb_ones_count_pattern_gen;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    ones_count_pattern_gen_if bif ();

    ones_count_pattern_gen #(.TICK_DIV(TD), .CNT_W(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t cycle %0d: got %0d expected %0d", name, $time, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] rot(input logic [3:0] p, input int r);
        logic [7:0] w;
        w = {p, p};
        return w[7-r -: 4];
    endfunction

    // Model: a run is described by its start edge and initial pattern; the visible
    // pattern is the initial one rotated by the number of whole tick periods elapsed.
    logic [3:0] m_pat, m_init;
    logic       m_busy, m_done, m_err, m_lit_vld;
    int         m_start, m_lit_code, ecyc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pat = 4'd0; m_init = 4'd0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_start = 0; ecyc = 0; m_lit_vld = 1'b0; m_lit_code = 0;
        end else begin
            int k;
            ecyc++;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_busy) begin
                k = ecyc - m_start;
                m_pat = rot(m_init, (k / TD) % 4);
                if (k == 4 * TD) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (bif.load) begin
                if (int'(bif.code) > 4) begin
                    m_err = 1'b1;
                end else begin
                    m_lit_vld  = 1'b1;
                    m_lit_code = int'(bif.code);
                    if (bif.code == 3'd0 || bif.code == 3'd4) begin
                        m_pat  = 4'((1 << int'(bif.code)) - 1);
                        m_done = 1'b1;
                    end else begin
                        m_init  = 4'((1 << int'(bif.code)) - 1);
                        m_pat   = m_init;
                        m_busy  = 1'b1;
                        m_start = ecyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("pattern", int'(bif.pattern), int'(m_pat));
            chk("busy", int'(bif.busy), int'(m_busy));
            chk("done", int'(bif.done), int'(m_done));
            chk("code_err", int'(bif.code_err), int'(m_err));
            if (m_lit_vld) chk("roundtrip_lights", $countones(bif.pattern), m_lit_code);
        end
    end

    // Drives a one-cycle load; returns at the negedge showing cycle 1 after the load edge.
    task automatic load_code(input logic [2:0] c);
        @(negedge clk);
        bif.load = 1'b1;
        bif.code = c;
        @(negedge clk);
        bif.load = 1'b0;
    endtask

    task automatic wait_to(input int from, input int to);
        repeat (to - from) @(negedge clk);
    endtask

    initial begin
        bif.load = 1'b0;
        bif.code = 3'd0;
        #2;
        chk("rst_pattern", int'(bif.pattern), 0);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_done", int'(bif.done), 0);
        chk("rst_err", int'(bif.code_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: code 2 full revolution
        load_code(3'd2);
        chk("t1_c1_pat", int'(bif.pattern), 4'b0011);
        chk("t1_c1_busy", int'(bif.busy), 1);
        wait_to(1, 5);   chk("t1_c5_pat", int'(bif.pattern), 4'b0110);
        wait_to(5, 9);   chk("t1_c9_pat", int'(bif.pattern), 4'b1100);
        wait_to(9, 13);  chk("t1_c13_pat", int'(bif.pattern), 4'b1001);
        wait_to(13, 16); chk("t1_c16_done", int'(bif.done), 0);
        chk("t1_c16_busy", int'(bif.busy), 1);
        wait_to(16, 17); chk("t1_c17_pat", int'(bif.pattern), 4'b0011);
        chk("t1_c17_done", int'(bif.done), 1);
        chk("t1_c17_busy", int'(bif.busy), 0);
        @(negedge clk);

        // 2: invalid codes
        for (int c = 5; c <= 7; c++) begin
            load_code(3'(c));
            chk("t2_err", int'(bif.code_err), 1);
            chk("t2_pat_hold", int'(bif.pattern), 4'b0011);
            chk("t2_done", int'(bif.done), 0);
            @(negedge clk);
        end

        // 3: single-pattern codes
        load_code(3'd0);
        chk("t3_c0_pat", int'(bif.pattern), 4'b0000);
        chk("t3_c0_done", int'(bif.done), 1);
        @(negedge clk);
        load_code(3'd4);
        chk("t3_c4_pat", int'(bif.pattern), 4'b1111);
        chk("t3_c4_done", int'(bif.done), 1);
        chk("t3_c4_busy", int'(bif.busy), 0);
        @(negedge clk);

        // 4: load during RUN ignored
        load_code(3'd3);
        wait_to(1, 5);
        bif.load = 1'b1;
        bif.code = 3'd1;
        @(negedge clk);
        bif.load = 1'b0;
        chk("t4_c6_pat", int'(bif.pattern), 4'b1110);
        wait_to(6, 9);   chk("t4_c9_pat", int'(bif.pattern), 4'b1101);
        wait_to(9, 13);  chk("t4_c13_pat", int'(bif.pattern), 4'b1011);
        wait_to(13, 17); chk("t4_c17_pat", int'(bif.pattern), 4'b0111);
        chk("t4_c17_done", int'(bif.done), 1);
        @(negedge clk);

        // 5: asynchronous reset mid-run
        load_code(3'd1);
        wait_to(1, 6);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_pat", int'(bif.pattern), 0);
        chk("t5_rst_busy", int'(bif.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_code(3'd1);
        chk("t5_restart_pat", int'(bif.pattern), 4'b0001);
        wait_to(1, 18);

        // 6: round-trip sweep
        for (int c = 0; c <= 4; c++) begin
            load_code(3'(c));
            wait_to(1, 19);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
